vgahdmi_fb: RTL and testbench



---
 rtl/vgahdmi_pkg.sv | 38 +++
 rtl/vgahdmi_tmds_enc.sv | 71 +++++++
 rtl/vgahdmi_fb.sv | 199 +++++++++++++++++++
 tb/tb_vgahdmi_fb.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/vgahdmi_pkg.sv
// Shared definitions for the vgahdmi framebuffer generator: pipeline control word,
// raster arithmetic, BPP legality and the DVI control symbols used by the TMDS encoders.
package vgahdmi_pkg;

    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    // Per-pixel control bits carried alongside the fetch pipeline
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic vb;
        logic load;
        logic adv;
    } vga_ctl_t;

    function automatic int raster_total(input int vis, input int front, input int sync, input int back);
        return vis + front + sync + back;
    endfunction

    function automatic bit bpp_legal(input int bpp);
        return (bpp == 1) || (bpp == 2) || (bpp == 4) || (bpp == 8);
    endfunction

    // Index is {c1, c0}
    function automatic logic [9:0] tmds_ctrl(input logic [1:0] c);
        case (c)
            2'b00:   return TMDS_CTRL_00;
            2'b01:   return TMDS_CTRL_01;
            2'b10:   return TMDS_CTRL_10;
            default: return TMDS_CTRL_11;
        endcase
    endfunction

endpackage

// File: rtl/vgahdmi_tmds_enc.sv
// One DVI 1.0 TMDS 8b/10b channel encoder with running-disparity DC balancing.
// Only instantiated when VGAHDMI_TMDS_EN is defined.
module vgahdmi_tmds_enc
    import vgahdmi_pkg::*;
(
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       de,
    input  logic [1:0] ctrl,
    output logic [9:0] tmds
);

    logic [3:0]        n1_data;
    logic [3:0]        n1_qm;
    logic              use_xnor;
    logic              acc;
    logic [8:0]        q_m;
    logic signed [5:0] bal;
    logic signed [5:0] disp_q, disp_d;
    logic [9:0]        tmds_q, tmds_d;

    always_comb begin
        n1_data = '0;
        for (int i = 0; i < 8; i++) n1_data = n1_data + 4'(data[i]);
        use_xnor = (n1_data > 4'd4) || ((n1_data == 4'd4) && !data[0]);

        q_m = '0;
        acc = data[0];
        q_m[0] = acc;
        for (int i = 1; i < 8; i++) begin
            acc = use_xnor ? ~(acc ^ data[i]) : (acc ^ data[i]);
            q_m[i] = acc;
        end
        q_m[8] = !use_xnor;

        n1_qm = '0;
        for (int i = 0; i < 8; i++) n1_qm = n1_qm + 4'(q_m[i]);
        // ones minus zeros of the 8 data bits = 2*n1 - 8
        bal = $signed({1'b0, n1_qm, 1'b0}) - 6'sd8;

        disp_d = disp_q;
        tmds_d = tmds_q;
        if (!de) begin
            disp_d = '0;
            tmds_d = tmds_ctrl(ctrl);
        end else if ((disp_q == 6'sd0) || (bal == 6'sd0)) begin
            tmds_d = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            disp_d = q_m[8] ? (disp_q + bal) : (disp_q - bal);
        end else if (((disp_q > 6'sd0) && (bal > 6'sd0)) || ((disp_q < 6'sd0) && (bal < 6'sd0))) begin
            tmds_d = {1'b1, q_m[8], ~q_m[7:0]};
            disp_d = disp_q + (q_m[8] ? 6'sd2 : 6'sd0) - bal;
        end else begin
            tmds_d = {1'b0, q_m[8], q_m[7:0]};
            disp_d = disp_q - (q_m[8] ? 6'sd0 : 6'sd2) + bal;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            disp_q <= '0;
            tmds_q <= '0;
        end else begin
            disp_q <= disp_d;
            tmds_q <= tmds_d;
        end
    end

    assign tmds = tmds_q;

endmodule

// File: rtl/vgahdmi_fb.sv
// vgahdmi_fb: programmable-timing framebuffer video generator, 1/2/4/8 bpp, optional X/Y doubling.
// Define VGAHDMI_TMDS_EN to add the parallel DVI TMDS word outputs tmds_r/tmds_g/tmds_b.
module vgahdmi_fb
    import vgahdmi_pkg::*;
#(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SYNC_POL  = 1,
    parameter int BPP       = 1,
    parameter int DBL_X     = 0,
    parameter int DBL_Y     = 0,
    parameter int ADDR_W    = 16
) (
    input  logic              clk_pixel,
    input  logic              reset_n,
    output logic [ADDR_W-1:0] dispAddr,
    input  logic [7:0]        dispData,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              vga_de,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              vblank_pulse
`ifdef VGAHDMI_TMDS_EN
    ,
    output logic [9:0]        tmds_r,
    output logic [9:0]        tmds_g,
    output logic [9:0]        tmds_b
`endif
);

    localparam int   H_TOTAL   = raster_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int   V_TOTAL   = raster_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
    localparam int   XW        = $clog2(H_TOTAL);
    localparam int   YW        = $clog2(V_TOTAL);
    localparam int   PPB       = bpp_legal(BPP) ? (8 / BPP) : 1;
    localparam int   PPB_LOG2  = $clog2(PPB);
    localparam int   STRIDE    = (H_VISIBLE >> DBL_X) / PPB;
    localparam bit   PARAM_OK  = bpp_legal(BPP) && (((H_VISIBLE >> DBL_X) % PPB) == 0);
    localparam logic SYNC_IDLE = (SYNC_POL == 0);

    generate
        if (!PARAM_OK) begin : g_param_check
            $error("vgahdmi_fb: BPP must be 1/2/4/8 and H_VISIBLE>>DBL_X a multiple of 8/BPP");
        end
    endgenerate

    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;
    logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
    vga_ctl_t          ctl1_q, ctl1_d, ctl2_q, ctl2_d;
    logic [7:0]        shift_q, shift_d;
    logic [23:0]       rgb_q, rgb_d;
    logic              de_q, de_d, hs_q, hs_d, vs_q, vs_d, vb_q, vb_d;

    logic              x_last, y_last, y_vis, first_clk, y_grp_last, grp_start;
    logic [XW-1:0]     fb_x;

    // Stage 1: raster counters, line base, fetch address and per-pixel control
    always_comb begin
        x_last     = (32'(x_q) == 32'(H_TOTAL - 1));
        y_last     = (32'(y_q) == 32'(V_TOTAL - 1));
        y_vis      = (32'(y_q) < 32'(V_VISIBLE));
        fb_x       = x_q >> DBL_X;
        first_clk  = (DBL_X == 0) || !x_q[0];
        y_grp_last = (DBL_Y == 0) || y_q[0];

        ctl1_d    = '0;
        ctl1_d.hs = (32'(x_q) >= 32'(H_VISIBLE + H_FRONT)) && (32'(x_q) < 32'(H_VISIBLE + H_FRONT + H_SYNC));
        ctl1_d.vs = (32'(y_q) >= 32'(V_VISIBLE + V_FRONT)) && (32'(y_q) < 32'(V_VISIBLE + V_FRONT + V_SYNC));
        ctl1_d.de = (32'(x_q) < 32'(H_VISIBLE)) && y_vis;
        ctl1_d.vb = (x_q == '0) && (32'(y_q) == 32'(V_VISIBLE));
        grp_start   = ctl1_d.de && first_clk && ((fb_x & XW'(PPB - 1)) == '0);
        ctl1_d.load = grp_start;
        ctl1_d.adv  = ctl1_d.de && first_clk && !grp_start;

        x_d = x_last ? '0 : x_q + XW'(1);
        y_d = y_q;
        if (x_last) y_d = y_last ? '0 : y_q + YW'(1);

        line_base_d = line_base_q;
        if (x_last) begin
            if (y_last)
                line_base_d = '0;
            else if (y_grp_last && y_vis)
                line_base_d = line_base_q + ADDR_W'(STRIDE);
        end

        disp_addr_d = disp_addr_q;
        if (!y_vis)
            disp_addr_d = '0;
        else if (grp_start)
            disp_addr_d = line_base_q + ADDR_W'(fb_x >> PPB_LOG2);
    end

    // Stages 2/3: dispData is valid while ctl2 holds the matching control word,
    // so the unpacked pixel feeds the output registers directly from shift_d.
    always_comb begin
        ctl2_d = ctl1_q;

        shift_d = shift_q;
        if (ctl2_q.load)
            shift_d = dispData;
        else if (ctl2_q.adv)
            shift_d = shift_q >> BPP;

        case (BPP)
            1:       rgb_d = {24{shift_d[0]}};
            2:       rgb_d = {3{{4{shift_d[1:0]}}}};
            4:       rgb_d = {3{{2{shift_d[3:0]}}}};
            default: rgb_d = {shift_d[7:5], shift_d[7:5], shift_d[7:6],
                              shift_d[4:2], shift_d[4:2], shift_d[4:3],
                              {4{shift_d[1:0]}}};
        endcase
        if (!ctl2_q.de) rgb_d = '0;

        de_d = ctl2_q.de;
        hs_d = ctl2_q.hs ^ SYNC_IDLE;
        vs_d = ctl2_q.vs ^ SYNC_IDLE;
        vb_d = ctl2_q.vb;
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            x_q         <= '0;
            y_q         <= '0;
            line_base_q <= '0;
            disp_addr_q <= '0;
            ctl1_q      <= '0;
            ctl2_q      <= '0;
            shift_q     <= '0;
            rgb_q       <= '0;
            de_q        <= 1'b0;
            hs_q        <= SYNC_IDLE;
            vs_q        <= SYNC_IDLE;
            vb_q        <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            line_base_q <= line_base_d;
            disp_addr_q <= disp_addr_d;
            ctl1_q      <= ctl1_d;
            ctl2_q      <= ctl2_d;
            shift_q     <= shift_d;
            rgb_q       <= rgb_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            vb_q        <= vb_d;
        end
    end

    assign dispAddr     = disp_addr_q;
    assign vga_r        = rgb_q[23:16];
    assign vga_g        = rgb_q[15:8];
    assign vga_b        = rgb_q[7:0];
    assign vga_de       = de_q;
    assign vga_hsync    = hs_q;
    assign vga_vsync    = vs_q;
    assign vblank_pulse = vb_q;

`ifdef VGAHDMI_TMDS_EN
    vgahdmi_tmds_enc u_enc_r (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .data      (rgb_q[23:16]),
        .de        (de_q),
        .ctrl      (2'b00),
        .tmds      (tmds_r)
    );

    vgahdmi_tmds_enc u_enc_g (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .data      (rgb_q[15:8]),
        .de        (de_q),
        .ctrl      (2'b00),
        .tmds      (tmds_g)
    );

    vgahdmi_tmds_enc u_enc_b (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .data      (rgb_q[7:0]),
        .de        (de_q),
        .ctrl      ({vs_q, hs_q}),
        .tmds      (tmds_b)
    );
`endif

endmodule

// File: tb/tb_vgahdmi_fb.sv
// Directed bench for vgahdmi_fb: three parameterisations share one clock and reset,
// each fed by a registered RAM model. Honours VGAHDMI_TMDS_EN for the TMDS ports.
module tb_vgahdmi_fb;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: defaults, 1 bpp ----------------
    logic [7:0]  mem_a [1024];
    logic [15:0] addr_a;
    logic [7:0]  data_a, r_a, g_a, b_a;
    logic        de_a, hs_a, vs_a, vb_a;
    always @(posedge clk) data_a <= mem_a[addr_a[9:0]];

    // ---------------- instance B: 8 bpp, doubled X/Y, short frame ----------------
    logic [7:0]  mem_b [1024];
    logic [15:0] addr_b;
    logic [7:0]  data_b, r_b, g_b, b_b;
    logic        de_b, hs_b, vs_b, vb_b;
    always @(posedge clk) data_b <= mem_b[addr_b[9:0]];

    // ---------------- instance C: 4 bpp, active-low syncs, short frame ----------------
    logic [7:0]  mem_c [1024];
    logic [15:0] addr_c;
    logic [7:0]  data_c, r_c, g_c, b_c;
    logic        de_c, hs_c, vs_c, vb_c;
    always @(posedge clk) data_c <= mem_c[addr_c[9:0]];

`ifdef VGAHDMI_TMDS_EN
    logic [9:0] tr_a, tg_a, tb_a, tr_b, tg_b, tb_b, tr_c, tg_c, tb_c;
    int         disp_sum, disp_max;
`endif

    vgahdmi_fb #(.BPP(1)) u_a (
        .clk_pixel (clk), .reset_n (reset_n), .dispAddr (addr_a), .dispData (data_a),
        .vga_r (r_a), .vga_g (g_a), .vga_b (b_a), .vga_de (de_a),
        .vga_hsync (hs_a), .vga_vsync (vs_a), .vblank_pulse (vb_a)
`ifdef VGAHDMI_TMDS_EN
        , .tmds_r (tr_a), .tmds_g (tg_a), .tmds_b (tb_a)
`endif
    );

    vgahdmi_fb #(.BPP(8), .DBL_X(1), .DBL_Y(1), .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)) u_b (
        .clk_pixel (clk), .reset_n (reset_n), .dispAddr (addr_b), .dispData (data_b),
        .vga_r (r_b), .vga_g (g_b), .vga_b (b_b), .vga_de (de_b),
        .vga_hsync (hs_b), .vga_vsync (vs_b), .vblank_pulse (vb_b)
`ifdef VGAHDMI_TMDS_EN
        , .tmds_r (tr_b), .tmds_g (tg_b), .tmds_b (tb_b)
`endif
    );

    vgahdmi_fb #(.BPP(4), .SYNC_POL(0), .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)) u_c (
        .clk_pixel (clk), .reset_n (reset_n), .dispAddr (addr_c), .dispData (data_c),
        .vga_r (r_c), .vga_g (g_c), .vga_b (b_c), .vga_de (de_c),
        .vga_hsync (hs_c), .vga_vsync (vs_c), .vblank_pulse (vb_c)
`ifdef VGAHDMI_TMDS_EN
        , .tmds_r (tr_c), .tmds_g (tg_c), .tmds_b (tb_c)
`endif
    );

    // Expected first-line colours of instance A (byte 0xA5 LSB-first, then a zero byte)
    logic [23:0] exp_q[$];

    int a_hs_rise, a_hs_w, a_de_cnt;
    int c_vs_rise, c_vs_cnt, c_vb_cnt, c_vb_first, c_de_cnt;

    task automatic drive_reset(input int ncyc);
        reset_n = 1'b0;
        repeat (ncyc) @(posedge clk);
        @(negedge clk);
    endtask

    // n = number of rising edges since reset release; outputs for raster x appear at n = x + 3
    task automatic run_cycles(input int ncyc);
        logic [23:0] exp_px;
        a_hs_rise = 0; a_hs_w = 0; a_de_cnt = 0;
        c_vs_rise = 0; c_vs_cnt = 0; c_vb_cnt = 0; c_vb_first = 0; c_de_cnt = 0;
        exp_q = {};
        exp_q.push_back(24'hFFFFFF); exp_q.push_back(24'h000000); exp_q.push_back(24'hFFFFFF);
        exp_q.push_back(24'h000000); exp_q.push_back(24'h000000); exp_q.push_back(24'hFFFFFF);
        exp_q.push_back(24'h000000); exp_q.push_back(24'hFFFFFF); exp_q.push_back(24'h000000);
`ifdef VGAHDMI_TMDS_EN
        disp_sum = 0; disp_max = 0;
`endif
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n <= 802) begin
                if (hs_a) begin
                    a_hs_w++;
                    if (a_hs_rise == 0) a_hs_rise = n;
                end
                if (de_a) a_de_cnt++;
            end
            if (n <= 9602) begin
                if (!vs_c) begin
                    c_vs_cnt++;
                    if (c_vs_rise == 0) c_vs_rise = n;
                end
                if (de_c) c_de_cnt++;
            end
            if (vb_c) begin
                c_vb_cnt++;
                if (c_vb_first == 0) c_vb_first = n;
            end
            if (n == 2)  check("a_de_pre", de_a, 1'b0);
            if (n >= 3 && n <= 11 && exp_q.size() > 0) begin
                exp_px = exp_q.pop_front();
                check($sformatf("a_pix%0d", n - 3), {r_a, g_a, b_a}, exp_px);
            end
            if (n == 8)    check("a_addr_n8", addr_a, 16'd0);
            if (n == 9)    check("a_addr_n9", addr_a, 16'd1);
            if (n == 17)   check("a_addr_n17", addr_a, 16'd2);
            if (n == 800)  check("a_addr_hold", addr_a, 16'd79);
            if (n == 801)  check("a_addr_line1", addr_a, 16'd80);
            if (n == 3)    check("b_pix00", {r_b, g_b, b_b}, 24'hFF0000);
            if (n == 4)    check("b_pix10", {r_b, g_b, b_b}, 24'hFF0000);
            if (n == 5)    check("b_pix20", {r_b, g_b, b_b}, 24'h0000FF);
            if (n == 803)  check("b_pix01", {r_b, g_b, b_b}, 24'hFF0000);
            if (n == 804)  check("b_pix11", {r_b, g_b, b_b}, 24'hFF0000);
            if (n == 801)  check("b_addr_line1", addr_b, 16'd0);
            if (n == 1600) check("b_addr_hold", addr_b, 16'd319);
            if (n == 1601) check("b_addr_line2", addr_b, 16'd320);
            if (n == 1603) check("b_pix02", {r_b, g_b, b_b}, 24'h00FF00);
            if (n == 1604) check("b_pix12", {r_b, g_b, b_b}, 24'h00FF00);
            if (n == 3)    check("c_pix0", {r_c, g_c, b_c}, 24'hCCCCCC);
            if (n == 4)    check("c_pix1", {r_c, g_c, b_c}, 24'h333333);
`ifdef VGAHDMI_TMDS_EN
            if (n == 701) begin
                check("tmds_b_blank", tb_a, 10'b0010101011);
                check("tmds_r_blank", tr_a, 10'b1101010100);
                check("tmds_g_blank", tg_a, 10'b1101010100);
            end
            if (n == 804) check("tmds_b_first0", tb_a, 10'b0100000000);
            if (n >= 804 && n <= 1443) begin
                disp_sum += 2 * $countones(tb_a) - 10;
                if (disp_sum > disp_max) disp_max = disp_sum;
                if (-disp_sum > disp_max) disp_max = -disp_sum;
            end
            if (n == 1443) check("tmds_disp_max8", disp_max <= 8, 1'b1);
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 8'h00;
            mem_b[i] = 8'h00;
            mem_c[i] = 8'h00;
        end
        mem_a[0]   = 8'hA5;
        mem_b[0]   = 8'hE0;
        mem_b[1]   = 8'h03;
        mem_b[320] = 8'h1C;
        mem_c[0]   = 8'h3C;

        drive_reset(4);
        check("rst_a_addr", addr_a, 16'd0);
        check("rst_a_rgb", {r_a, g_a, b_a}, 24'h0);
        check("rst_a_de", de_a, 1'b0);
        check("rst_a_hs", hs_a, 1'b0);
        check("rst_a_vs", vs_a, 1'b0);
        check("rst_a_vb", vb_a, 1'b0);
        check("rst_c_hs", hs_c, 1'b1);
        check("rst_c_vs", vs_c, 1'b1);

        reset_n = 1'b1;
        run_cycles(21900);
        check("a_hs_rise", a_hs_rise, 659);
        check("a_hs_width", a_hs_w, 96);
        check("a_de_line", a_de_cnt, 640);
        check("c_vs_rise", c_vs_rise, 6403);
        check("c_vs_width", c_vs_cnt, 1600);
        check("c_de_frame", c_de_cnt, 3840);
        check("c_vb_count", c_vb_cnt, 2);
        check("c_vb_first", c_vb_first, 4803);

        // Reset in the middle of an active line
        check("mid_c_de_before", de_c, 1'b1);
        reset_n = 1'b0;
        #1;
        check("mid_c_de", de_c, 1'b0);
        check("mid_c_rgb", {r_c, g_c, b_c}, 24'h0);
        check("mid_c_hs", hs_c, 1'b1);
        check("mid_a_hs", hs_a, 1'b0);
        drive_reset(3);
        check("mid_c_addr", addr_c, 16'd0);
        check("mid_a_addr", addr_a, 16'd0);
        check("mid_c_vs", vs_c, 1'b1);
        check("mid_a_de", de_a, 1'b0);

        reset_n = 1'b1;
        run_cycles(1700);
        check("re_a_hs_rise", a_hs_rise, 659);
        check("re_a_hs_width", a_hs_w, 96);
        check("re_a_de_line", a_de_cnt, 640);
        check("re_c_vb_none", c_vb_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
